// File: rtl/config_adc_clk_unit_if.sv
// Byte-wide PC command link and ADC capture bus shared between the test host
// and config_adc_clk_unit.
interface config_adc_clk_unit_if;
    logic        pc_cmd_valid;
    logic [7:0]  pc_cmd_data;
    logic        pc_ack;
    logic        config_en;
    logic [31:0] config_data;
    logic [15:0] adc_in;
    logic [15:0] adc_data;
    logic        adc_ready;

    modport master (
        output pc_cmd_valid,
        output pc_cmd_data,
        output adc_in,
        input  pc_ack,
        input  config_en,
        input  config_data,
        input  adc_data,
        input  adc_ready
    );

    modport slave (
        input  pc_cmd_valid,
        input  pc_cmd_data,
        input  adc_in,
        output pc_ack,
        output config_en,
        output config_data,
        output adc_data,
        output adc_ready
    );
endinterface

// File: rtl/config_adc_clk_unit.sv
// Test-system front end: PC frame parser, three even-ratio clock dividers with
// rising-edge counters, and a synchronized ADC sampler clocked off adc_clk.
module config_adc_clk_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic div_clk,
    output logic rise
);
    localparam int HALF = DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(HALF - 1));
    // The toggle at this edge is a 0->1 transition when the output is still low.
    assign rise = wrap & ~div_clk;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q   <= '0;
            div_clk <= 1'b0;
        end else if (wrap) begin
            cnt_q   <= '0;
            div_clk <= ~div_clk;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end
endmodule

module config_adc_clk_unit #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT     = 1000,
    parameter int         CLK_OUT_DIV = 2,
    parameter int         DUT_DIV     = 4,
    parameter int         ADC_DIV     = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    config_adc_clk_unit_if.slave        bus,
    output logic                        clk_out,
    output logic                        dut_clk,
    output logic                        adc_clk,
    output logic [31:0]                 dut_clk_counter,
    output logic [31:0]                 adc_clk_counter
);
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        D3,
        D2,
        D1,
        D0
    } parse_state_t;

    parse_state_t  state_q, state_d;
    logic [23:0]   shift_q, shift_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [31:0]   cfg_q, cfg_d;
    logic          ack_q, ack_d;
    logic          en_q, en_d;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idle_q  <= '0;
            cfg_q   <= '0;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idle_q  <= idle_d;
            cfg_q   <= cfg_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idle_d  = idle_q;
        cfg_d   = cfg_q;
        ack_d   = 1'b0;
        en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (bus.pc_cmd_valid && bus.pc_cmd_data == HEADER) begin
                    state_d = D3;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                // Inside a frame every byte is payload, HEADER included.
                if (bus.pc_cmd_valid) begin
                    ack_d  = 1'b1;
                    idle_d = '0;
                    if (state_q == D0) begin
                        cfg_d   = {shift_q, bus.pc_cmd_data};
                        en_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        shift_d = {shift_q[15:0], bus.pc_cmd_data};
                        case (state_q)
                            D3:      state_d = D2;
                            D2:      state_d = D1;
                            default: state_d = D0;
                        endcase
                    end
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    // TIMEOUT-th silent cycle: drop the partial frame.
                    state_d = IDLE;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        endcase
    end

    assign bus.pc_ack      = ack_q;
    assign bus.config_en   = en_q;
    assign bus.config_data = cfg_q;

    logic clk_out_rise;
    logic dut_rise;
    logic adc_rise;

    config_adc_clk_div #(.DIV(CLK_OUT_DIV)) u_div_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_clk (clk_out),
        .rise    (clk_out_rise)
    );

    config_adc_clk_div #(.DIV(DUT_DIV)) u_div_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_clk (dut_clk),
        .rise    (dut_rise)
    );

    config_adc_clk_div #(.DIV(ADC_DIV)) u_div_adc (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_clk (adc_clk),
        .rise    (adc_rise)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            dut_clk_counter <= '0;
            adc_clk_counter <= '0;
        end else begin
            if (dut_rise) dut_clk_counter <= dut_clk_counter + 32'd1;
            if (adc_rise) adc_clk_counter <= adc_clk_counter + 32'd1;
        end
    end

    // ---- stage p1/p2: two-flop synchronizer, adc_clk rise flag delayed one edge
    logic [15:0] adc_sync_p1, adc_sync_p2;
    logic        adc_vld_p1;
    logic [15:0] adc_data_q;
    logic        adc_ready_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            adc_sync_p1 <= '0;
            adc_sync_p2 <= '0;
            adc_vld_p1  <= 1'b0;
            adc_data_q  <= '0;
            adc_ready_q <= 1'b0;
        end else begin
            adc_sync_p1 <= bus.adc_in;
            adc_sync_p2 <= adc_sync_p1;
            adc_vld_p1  <= adc_rise;
            adc_ready_q <= adc_vld_p1;
            if (adc_vld_p1) adc_data_q <= adc_sync_p2;
        end
    end

    assign bus.adc_data  = adc_data_q;
    assign bus.adc_ready = adc_ready_q;

    logic unused_rise;
    assign unused_rise = clk_out_rise;
endmodule

// File: tb/tb_config_adc_clk_unit.sv
// Directed bench for config_adc_clk_unit: reset, framing, noise, timeout,
// divider counts/duty and ADC sampling timing.
module tb_config_adc_clk_unit;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_out, dut_clk, adc_clk;
    logic [31:0] dut_clk_counter, adc_clk_counter;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ack_cnt = 0, en_cnt = 0, en_wo_ack = 0, rdy_cnt = 0;

    always #5 clk = ~clk;

    config_adc_clk_unit_if bus ();

    config_adc_clk_unit #(
        .HEADER      (8'hA5),
        .TIMEOUT     (TIMEOUT),
        .CLK_OUT_DIV (2),
        .DUT_DIV     (4),
        .ADC_DIV     (10)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus.slave),
        .clk_out         (clk_out),
        .dut_clk         (dut_clk),
        .adc_clk         (adc_clk),
        .dut_clk_counter (dut_clk_counter),
        .adc_clk_counter (adc_clk_counter)
    );

    // Pulse bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (bus.pc_ack) ack_cnt++;
            if (bus.config_en) en_cnt++;
            if (bus.config_en && !bus.pc_ack) en_wo_ack++;
            if (bus.adc_ready) rdy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.pc_cmd_valid = 1'b1;
        bus.pc_cmd_data  = b;
        tick();
    endtask

    task automatic idle(input int n);
        bus.pc_cmd_valid = 1'b0;
        bus.pc_cmd_data  = 8'h00;
        repeat (n) tick();
    endtask

    initial begin
        int ab, eb, rb;
        int hi_dut, hi_adc, hi_out, tog_out;
        logic prev_out;

        rst_n            = 1'b1;
        bus.pc_cmd_valid = 1'b0;
        bus.pc_cmd_data  = 8'h00;
        bus.adc_in       = 16'h1234;

        // Reset state
        repeat (3) tick();
        check("rst_flags", {26'd0, clk_out, dut_clk, adc_clk, bus.pc_ack, bus.config_en, bus.adc_ready}, 32'd0);
        check("rst_config_data", bus.config_data, 32'd0);
        check("rst_adc_data", {16'd0, bus.adc_data}, 32'd0);
        check("rst_dut_cnt", dut_clk_counter, 32'd0);
        check("rst_adc_cnt", adc_clk_counter, 32'd0);

        rst_n = 1'b0;
        cyc   = 0;
        tick();
        check("clk_out_first", {31'd0, clk_out}, 32'd1);
        check("dut_clk_c1", {31'd0, dut_clk}, 32'd0);
        tick();
        check("dut_clk_rise_c2", {31'd0, dut_clk}, 32'd1);
        check("dut_cnt_c2", dut_clk_counter, 32'd1);
        tick(); tick();
        check("adc_clk_c4", {31'd0, adc_clk}, 32'd0);
        tick();
        check("adc_clk_rise_c5", {31'd0, adc_clk}, 32'd1);
        check("adc_cnt_c5", adc_clk_counter, 32'd1);
        tick();
        check("adc_ready_c6", {31'd0, bus.adc_ready}, 32'd1);
        check("adc_data_c6", {16'd0, bus.adc_data}, 32'h1234);

        // Basic frame
        ab = ack_cnt; eb = en_cnt;
        send(8'hA5); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        check("frame1_en_last", {31'd0, bus.config_en}, 32'd1);
        check("frame1_ack_last", {31'd0, bus.pc_ack}, 32'd1);
        check("frame1_data", bus.config_data, 32'h12345678);
        idle(1);
        check("frame1_en_clear", {31'd0, bus.config_en}, 32'd0);
        idle(2);
        check("frame1_acks", ack_cnt - ab, 32'd5);
        check("frame1_ens", en_cnt - eb, 32'd1);

        // Noise then HEADER-as-data
        ab = ack_cnt; eb = en_cnt;
        send(8'h00);
        check("noise_00_noack", {31'd0, bus.pc_ack}, 32'd0);
        send(8'hFF);
        check("noise_ff_noack", {31'd0, bus.pc_ack}, 32'd0);
        send(8'hA5); send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
        idle(3);
        check("frame2_data", bus.config_data, 32'hA5000001);
        check("frame2_acks", ack_cnt - ab, 32'd5);
        check("frame2_ens", en_cnt - eb, 32'd1);

        // Timeout drops the partial frame
        ab = ack_cnt; eb = en_cnt;
        send(8'hA5); send(8'h11); send(8'h22);
        idle(TIMEOUT + 2);
        check("timeout_no_en", en_cnt - eb, 32'd0);
        check("timeout_data_held", bus.config_data, 32'hA5000001);
        send(8'hA5); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        idle(3);
        check("frame3_data", bus.config_data, 32'hDEADBEEF);
        check("frame3_ens", en_cnt - eb, 32'd1);
        check("frame3_acks", ack_cnt - ab, 32'd8);

        // One cycle short of TIMEOUT keeps the frame alive
        eb = en_cnt;
        send(8'hA5); send(8'h01); send(8'h02);
        idle(TIMEOUT - 1);
        send(8'h03); send(8'h04);
        idle(2);
        check("no_timeout_data", bus.config_data, 32'h01020304);
        check("no_timeout_ens", en_cnt - eb, 32'd1);

        // Back-to-back frames
        eb = en_cnt;
        send(8'hA5); send(8'hC0); send(8'hFF); send(8'hEE); send(8'h01);
        send(8'hA5); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
        idle(2);
        check("b2b_data", bus.config_data, 32'h0A0B0C0D);
        check("b2b_ens", en_cnt - eb, 32'd2);
        check("en_aligned_ack", en_wo_ack, 32'd0);

        // Clocks over 1000 cycles from a fresh reset
        rst_n = 1'b1;
        tick();
        check("rst2_data", bus.config_data, 32'd0);
        rst_n = 1'b0;
        cyc = 0;
        hi_dut = 0; hi_adc = 0; hi_out = 0; tog_out = 0;
        prev_out = clk_out;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (dut_clk) hi_dut++;
            if (adc_clk) hi_adc++;
            if (clk_out) hi_out++;
            if (clk_out != prev_out) tog_out++;
            prev_out = clk_out;
        end
        check("dut_cnt_1000", dut_clk_counter, 32'd250);
        check("adc_cnt_1000", adc_clk_counter, 32'd100);
        check("clk_out_toggles", tog_out, 32'd1000);
        check("clk_out_duty", hi_out, 32'd500);
        check("dut_clk_duty", hi_dut, 32'd500);
        check("adc_clk_duty", hi_adc, 32'd500);
        check("adc_data_pre", {16'd0, bus.adc_data}, 32'h1234);

        // ADC input change mid-run
        rb = rdy_cnt;
        bus.adc_in = 16'hABCD;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("adc_ready_phase", {31'd0, bus.adc_ready}, (cyc % 10 == 6) ? 32'd1 : 32'd0);
            check("adc_data_seq", {16'd0, bus.adc_data}, (cyc >= 1006) ? 32'hABCD : 32'h1234);
        end
        idle(1);
        check("adc_ready_count", rdy_cnt - rb, 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/config_adc_clk_unit.md
Name: config_adc_clk_unit

Overview:
Front-end service block for the test system. It combines three functions:
- PC command parser: assembles framed bytes into a 32-bit configuration word with an enable pulse.
- Clock manager: produces three divided clocks (clk_out, dut_clk, adc_clk) plus edge counters.
- ADC capture interface: samples the 16-bit ADC bus on each adc_clk rising edge and flags each new sample.

It sits between the PC link/DUT pins and the test FSM, DIO controller and result analyzer.

Parameters:
HEADER, 8'hA5, frame start byte
TIMEOUT, 1000, idle cycles inside a frame before abort (>=1)
CLK_OUT_DIV, 2, clk_out division ratio (even, >=2)
DUT_DIV, 4, dut_clk division ratio (even, >=2)
ADC_DIV, 10, adc_clk division ratio (even, >=2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on clk rising edge
pc_cmd_valid  input  1  PC byte valid, one byte per cycle when high
pc_cmd_data  input  8  PC byte
pc_ack  output  1  one-cycle pulse per consumed byte
config_en  output  1  one-cycle pulse when a full frame is decoded
config_data  output  32  last decoded configuration word
adc_in  input  16  raw ADC bus (asynchronous to clk)
adc_data  output  16  captured ADC sample
adc_ready  output  1  one-cycle pulse, new adc_data valid
clk_out  output  1  clk / CLK_OUT_DIV
dut_clk  output  1  clk / DUT_DIV
adc_clk  output  1  clk / ADC_DIV
dut_clk_counter  output  32  count of dut_clk rising edges
adc_clk_counter  output  32  count of adc_clk rising edges

Behaviour:
Reset (rst_n=1 at a clk edge):
- All outputs go to 0, and all counters and divider state clear.
- The parser returns to IDLE, and the synchronizer flops clear.
- Reset takes priority over every other event, including a reset in mid-frame, which discards the partial frame.

Parser, states IDLE, D3, D2, D1, D0:
- IDLE:
  - valid && data==HEADER -> D3, with pc_ack=1 next cycle.
  - Any other byte is ignored: no ack, no state change.
- D3..D0: each valid byte is shifted into a shift register MSB-first (D3 holds bits 31:24) and is acked. A byte equal to HEADER is treated as data.
- The D0 byte completes the frame:
  - config_data updates.
  - config_en=1 in the same cycle as that byte's pc_ack (one cycle after the valid cycle).
  - State returns to IDLE.
- Timeout: an idle counter resets on every valid byte in D3..D0. After TIMEOUT consecutive cycles without valid, the parser goes to IDLE. The partial frame is dropped and config_data is unchanged.
- Between frames, config_data holds its value.
- Back-to-back frames with no gap are supported. The next HEADER may arrive in the cycle after the D0 byte.

Divider, identical for each clock with ratio N:
- A counter counts 0..N/2-1. When it reaches N/2-1, the counter wraps to 0 and the output toggles.
- The first rising edge is N/2 cycles after reset release.
- Duty cycle is 50%, and the period is N clk cycles.

Edge counters:
- dut_clk_counter and adc_clk_counter increment on the same clk edge at which the respective output toggles 0->1.
- They wrap from 2^32-1 to 0.

ADC capture:
- adc_in passes through a 2-flop synchronizer (s1<=adc_in, s2<=s1) every cycle.
- On the clk edge following an adc_clk 0->1 toggle:
  - adc_data<=s2.
  - adc_ready=1 for exactly one cycle.
- A sample therefore reflects adc_in as present at least 3 edges earlier.
- adc_data holds between samples.
- adc_ready pulses once per adc_clk period (every ADC_DIV cycles).

Independence:
- The parser, the dividers and the ADC path run concurrently.
- Parser traffic never stalls the clocks or ADC capture.

Test Plan:
1. Reset: hold rst_n=1 for 3 cycles, then release -> all outputs 0 during reset. The first dut_clk rise occurs 2 cycles after release, and the first adc_clk rise 5 cycles after release (defaults).
2. Frame: send A5,12,34,56,78 on consecutive cycles -> 5 single-cycle pc_ack pulses. config_data=32'h12345678, and config_en pulses once, aligned with the last ack.
3. Noise and HEADER-as-data: send 00,FF, then A5,A5,00,00,01 -> no ack for 00 or FF. config_data=32'hA5000001 with one config_en pulse.
4. Timeout: send A5,11,22, then idle for TIMEOUT+2 cycles, then A5,DE,AD,BE,EF -> there is no config_en after the partial frame. The final config_data=32'hDEADBEEF.
5. Clocks: run 1000 cycles -> dut_clk_counter=250, adc_clk_counter=100. clk_out toggles every cycle, and each output has a 50% duty cycle.
6. ADC: drive adc_in=16'h1234 steadily, change it to 16'hABCD mid-run, and run for 100 cycles -> adc_ready pulses every 10 cycles, one cycle after each adc_clk rise. adc_data goes from 1234 to ABCD within one adc_clk period once the 3-cycle synchronizer latency has passed.
